halt_controller: RTL and testbench
==================================

// Module: halt_controller
// PURPOSE
//  Sequences processor stop/restart around the HALT encoding (32'hFFFF_FFFF) seen in ID.
//  Freezes fetch, squashes HALT and younger slots, and waits for older instructions in EX/MEM/WB to retire.
//  Then reports a stable halted state with the HALT PC.
//  On resume, redirects fetch to halt_pc+4. Sits beside the hazard unit; its outputs OR into the IF/ID stall/flush nets.
// PARAMETERS
//  XLEN          32             datapath/PC width
//  HALT_INSTR    32'hFFFF_FFFF  encoding treated as HALT
//  DRAIN_CYCLES  3              cycles for older instrs to leave EX->MEM->WB (1..15)
// PORTS
//  clk            in   1     system clock, rising edge
//  rst_n          in   1     async active-low reset
//  id_instr       in   XLEN  instruction in ID
//  id_pc          in   XLEN  PC of instruction in ID
//  id_valid       in   1     ID slot holds a real instruction
//  id_stall       in   1     hazard unit holding ID this cycle
//  ex_flush       in   1     taken branch/jump resolved in EX (redirect this cycle)
//  resume         in   1     single-cycle restart request
//  stall_fetch    out  1     hold PC and IF/ID register
//  flush_id       out  1     turn ID slot into bubble
//  halted         out  1     pipeline empty and stopped
//  halt_pc        out  XLEN  PC of HALT (0 when not halted)
//  redirect_valid out  1     load PC from redirect_pc this cycle
//  redirect_pc    out  XLEN  restart address
// BEHAVIOUR
//  States: RUN, DRAIN, HALTED, RESTART.
//  Reset: RUN; all outputs 0, halt_pc_q=0, drain_cnt=0.
//  detect = state==RUN & id_valid & !id_stall & !ex_flush & id_instr==HALT_INSTR.
//  RUN:
//   - detect -> DRAIN; halt_pc_q<=id_pc; drain_cnt<=DRAIN_CYCLES.
//   - flush_id=detect (combinational, so HALT itself is squashed, never reaches EX).
//   - stall_fetch=detect.
//  DRAIN:
//   - stall_fetch=1, flush_id=1; drain_cnt decrements each cycle; at drain_cnt==1 -> HALTED.
//   - ex_flush=1 (older branch taken; HALT was wrong-path) -> RUN.
//     In that case stall_fetch=0 in that same cycle, so the EX redirect wins; halt_pc_q<=0.
//  HALTED:
//   - stall_fetch=1, flush_id=1, halted=1, halt_pc=halt_pc_q.
//   - resume -> RESTART.
//  RESTART (exactly 1 cycle):
//   - redirect_valid=1, redirect_pc=halt_pc_q+4 (mod 2^XLEN; wraps from FFFF_FFFC to 0).
//   - stall_fetch=0, flush_id=1, halted=0 -> RUN; halt_pc_q<=0.
//  Latency:
//   - HALT in ID to halted=1 is DRAIN_CYCLES+1 edges.
//   - resume to first new fetch is 1 cycle.
//  Edge cases:
//   - resume outside HALTED is ignored.
//   - A second HALT is undetectable until RUN (fetch frozen).
//   - Consecutive HALTs are allowed after restart.
//   - id_stall=1 with HALT in ID: no detect until the stall drops (one detection per HALT).
//   - rst_n low mid-DRAIN/HALTED: immediate RUN, outputs 0.
//  redirect_pc=0 whenever redirect_valid=0.
// CONFIGURATION
//  HALT_SINGLE_STEP_EN defined:
//   - Adds input step (1b); step is honoured only in HALTED. resume beats step if both are high.
//   - step -> RESTART, and a step_pending flag is set.
//   - In RUN with step_pending, the first id_valid & !id_stall & !ex_flush instruction is the step point:
//     it is not flushed (flush_id=0) and executes normally; stall_fetch=1 that cycle;
//     halt_pc_q<=its id_pc; DRAIN; step_pending cleared.
//   - A stepped HALT instruction is treated as a normal HALT detect.
//  Not defined: no step port; step_pending tied 0.
// STRUCTURE
//  Package halt_pkg:
//   - typedef enum logic [1:0] {HC_RUN, HC_DRAIN, HC_HALTED, HC_RESTART} halt_state_e
//   - localparam HALT_INSTR_DEFAULT = 32'hFFFF_FFFF
//  No sub-module; single always_ff (state, drain_cnt, halt_pc_q, step_pending) plus one always_comb.
// TESTING
//  T1 HALT at id_pc=0x40, DRAIN_CYCLES=3:
//   - flush_id=1 same cycle, halted=1 after 4 edges, halt_pc=0x40.
//   - resume -> redirect_valid=1 pc=0x44 for 1 cycle, then RUN.
//  T2 HALT in ID while id_stall=1 for 2 cycles: detection only on the cycle id_stall=0; halted after DRAIN_CYCLES+1.
//  T3 ex_flush=1 on 2nd DRAIN cycle: back to RUN, stall_fetch=0 that cycle, halted never 1, halt_pc=0.
//  T4 halt_pc=0xFFFF_FFFC, resume: redirect_pc=0x0000_0000.
//  T5 rst_n deasserted while HALTED: all outputs 0 asynchronously; after release, state=RUN; resume ignored.
//  T6 [HALT_SINGLE_STEP_EN] halted at 0x40, step:
//   - redirect 0x44; instr at 0x44 executes (flush_id=0).
//   - halted again after DRAIN_CYCLES+1 with halt_pc=0x44.

Source files
------------

// File: rtl/halt_pkg.sv
// ---------------------------------------------------------------------------
// halt_pkg
// Shared types and constants for the halt controller.
//   halt_state_e        : controller state encoding
//   HALT_INSTR_DEFAULT  : instruction word recognised as HALT
//   DRAIN_CNT_W         : width of the drain counter (DRAIN_CYCLES up to 15)
// ---------------------------------------------------------------------------
package halt_pkg;

    typedef enum logic [1:0] {
        HC_RUN     = 2'd0,
        HC_DRAIN   = 2'd1,
        HC_HALTED  = 2'd2,
        HC_RESTART = 2'd3
    } halt_state_e;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;
    localparam int          DRAIN_CNT_W        = 4;

endpackage : halt_pkg

// File: rtl/halt_controller.sv
// ---------------------------------------------------------------------------
// halt_controller
// Stops the pipeline when a HALT encoding is accepted in ID, waits for the
// older instructions in EX/MEM/WB to retire, reports a stable halted state
// with the HALT PC, and restarts fetch at halt_pc+4 on resume.  Its stall and
// flush outputs are ORed with the hazard unit's IF/ID controls.
//
// Optional feature macro: HALT_SINGLE_STEP_EN
//   Adds a 'step' input.  From HALTED, step restarts the core for exactly one
//   instruction, which executes normally and then halts again at its PC.
//
// Ports
//   clk            in   1     system clock, rising edge
//   rst_n          in   1     asynchronous active-low reset
//   id_instr       in   XLEN  instruction in ID
//   id_pc          in   XLEN  PC of the instruction in ID
//   id_valid       in   1     ID holds a real instruction
//   id_stall       in   1     hazard unit holds ID this cycle
//   ex_flush       in   1     taken branch/jump redirect from EX this cycle
//   resume         in   1     single-cycle restart request
//   step           in   1     single-step request (HALT_SINGLE_STEP_EN only)
//   stall_fetch    out  1     hold PC and IF/ID register
//   flush_id       out  1     turn the ID slot into a bubble
//   halted         out  1     pipeline empty and stopped
//   halt_pc        out  XLEN  PC of HALT while halted, else 0
//   redirect_valid out  1     load PC from redirect_pc this cycle
//   redirect_pc    out  XLEN  restart address, 0 when redirect_valid=0
// ---------------------------------------------------------------------------
module halt_controller
    import halt_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] HALT_INSTR   = XLEN'(HALT_INSTR_DEFAULT),
    parameter int              DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic            id_valid,
    input  logic            id_stall,
    input  logic            ex_flush,
    input  logic            resume,
`ifdef HALT_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic            stall_fetch,
    output logic            flush_id,
    output logic            halted,
    output logic [XLEN-1:0] halt_pc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    halt_state_e            state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [XLEN-1:0]        halt_pc_q, halt_pc_d;
    logic                   step_pending_q, step_pending_d;

    logic                   id_accept;
    logic                   detect;
    logic                   step_hit;

    // An instruction is "accepted" in ID only when it will actually advance:
    // a stalled slot is seen again next cycle, and a slot being flushed by an
    // older branch is wrong-path.  This gives one detection per HALT.
    assign id_accept = (state_q == HC_RUN) & id_valid & ~id_stall & ~ex_flush;
    assign detect    = id_accept & (id_instr == HALT_INSTR);
    assign step_hit  = id_accept & step_pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= HC_RUN;
            drain_cnt_q    <= '0;
            halt_pc_q      <= '0;
            step_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            halt_pc_q      <= halt_pc_d;
            step_pending_q <= step_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        halt_pc_d      = halt_pc_q;
        step_pending_d = step_pending_q;
        stall_fetch    = 1'b0;
        flush_id       = 1'b0;
        halted         = 1'b0;
        halt_pc        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        unique case (state_q)
            HC_RUN: begin
                if (detect) begin
                    // HALT is squashed in ID so it never reaches EX; a stepped
                    // HALT is just a HALT, so any pending step is consumed.
                    state_d        = HC_DRAIN;
                    halt_pc_d      = id_pc;
                    drain_cnt_d    = DRAIN_CNT_W'(DRAIN_CYCLES);
                    stall_fetch    = 1'b1;
                    flush_id       = 1'b1;
                    step_pending_d = 1'b0;
                end else if (step_hit) begin
                    // The stepped instruction proceeds; only fetch is frozen
                    // behind it, then it drains like a HALT would.
                    state_d        = HC_DRAIN;
                    halt_pc_d      = id_pc;
                    drain_cnt_d    = DRAIN_CNT_W'(DRAIN_CYCLES);
                    stall_fetch    = 1'b1;
                    step_pending_d = 1'b0;
                end
            end

            HC_DRAIN: begin
                flush_id = 1'b1;
                if (ex_flush) begin
                    // An older branch was taken: the HALT was wrong-path.
                    // Release fetch so the EX redirect takes effect now.
                    state_d     = HC_RUN;
                    halt_pc_d   = '0;
                    drain_cnt_d = '0;
                end else begin
                    stall_fetch = 1'b1;
                    if (drain_cnt_q == DRAIN_CNT_W'(1)) begin
                        state_d     = HC_HALTED;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
                    end
                end
            end

            HC_HALTED: begin
                stall_fetch = 1'b1;
                flush_id    = 1'b1;
                halted      = 1'b1;
                halt_pc     = halt_pc_q;
                if (resume) begin
                    state_d = HC_RESTART;
                end
`ifdef HALT_SINGLE_STEP_EN
                else if (step) begin
                    state_d        = HC_RESTART;
                    step_pending_d = 1'b1;
                end
`endif
            end

            HC_RESTART: begin
                // Addition wraps modulo 2^XLEN by construction.
                redirect_valid = 1'b1;
                redirect_pc    = halt_pc_q + XLEN'(4);
                flush_id       = 1'b1;
                halt_pc_d      = '0;
                state_d        = HC_RUN;
            end

            default: begin
                state_d = HC_RUN;
            end
        endcase
    end

endmodule : halt_controller

// File: tb/tb_halt_controller.sv
// ---------------------------------------------------------------------------
// tb_halt_controller
// Table-driven bench for halt_controller (DRAIN_CYCLES = 3).  Each record is
// one clock cycle: inputs driven after the falling edge, expected outputs
// pushed to a scoreboard queue, outputs sampled 1 ns later and compared
// against the popped expectation.
// ---------------------------------------------------------------------------
module tb_halt_controller;

    localparam int          XLEN = 32;
    localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic            id_valid;
    logic            id_stall;
    logic            ex_flush;
    logic            resume;
`ifdef HALT_SINGLE_STEP_EN
    logic            step;
`endif
    logic            stall_fetch;
    logic            flush_id;
    logic            halted;
    logic [XLEN-1:0] halt_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    typedef struct {
        string       name;
        logic        rn, vld, stl, exf, res, stp;
        logic [31:0] ins, pc;
        logic        e_stall, e_flush, e_halted;
        logic [31:0] e_hpc;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    typedef struct {
        string       name;
        logic [98:0] exp_bits;
    } sb_t;

    vec_t vt[$];
    sb_t  sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    halt_controller #(
        .XLEN        (XLEN),
        .HALT_INSTR  (HLT),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_valid      (id_valid),
        .id_stall      (id_stall),
        .ex_flush      (ex_flush),
        .resume        (resume),
`ifdef HALT_SINGLE_STEP_EN
        .step          (step),
`endif
        .stall_fetch   (stall_fetch),
        .flush_id      (flush_id),
        .halted        (halted),
        .halt_pc       (halt_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    function automatic vec_t mk(string n, logic rn, logic vld, logic stl, logic exf,
                                logic res, logic stp, logic [31:0] ins, logic [31:0] pc,
                                logic es, logic ef, logic eh, logic [31:0] ehpc,
                                logic erv, logic [31:0] erpc);
        vec_t v;
        v.name = n; v.rn = rn; v.vld = vld; v.stl = stl; v.exf = exf; v.res = res;
        v.stp = stp; v.ins = ins; v.pc = pc;
        v.e_stall = es; v.e_flush = ef; v.e_halted = eh; v.e_hpc = ehpc;
        v.e_rv = erv; v.e_rpc = erpc;
        return v;
    endfunction

    // Shorthands: an idle cycle, and the three fixed-output controller phases.
    function automatic vec_t idle(string n);
        return mk(n, 1, 0, 0, 0, 0, 0, NOP, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    endfunction
    function automatic vec_t drain(string n);
        return mk(n, 1, 0, 0, 0, 0, 0, NOP, 32'h0, 1, 1, 0, 32'h0, 0, 32'h0);
    endfunction
    function automatic vec_t hlt(string n, logic [31:0] pc, logic res);
        return mk(n, 1, 0, 0, 0, res, 0, NOP, 32'h0, 1, 1, 1, pc, 0, 32'h0);
    endfunction
    function automatic vec_t rst(string n, logic [31:0] pc);
        return mk(n, 1, 0, 0, 0, 0, 0, NOP, 32'h0, 0, 1, 0, 32'h0, 1, pc);
    endfunction
    function automatic vec_t halt_in(string n, logic [31:0] pc);
        return mk(n, 1, 1, 0, 0, 0, 0, HLT, pc, 1, 1, 0, 32'h0, 0, 32'h0);
    endfunction

    task automatic apply(input vec_t v);
        sb_t         e;
        sb_t         got;
        logic [98:0] act;
        @(negedge clk);
        rst_n    = v.rn;
        id_valid = v.vld;
        id_stall = v.stl;
        ex_flush = v.exf;
        resume   = v.res;
        id_instr = v.ins;
        id_pc    = v.pc;
`ifdef HALT_SINGLE_STEP_EN
        step     = v.stp;
`endif
        e.name     = v.name;
        e.exp_bits = {v.e_stall, v.e_flush, v.e_halted, v.e_hpc, v.e_rv, v.e_rpc};
        sb_q.push_back(e);
        #1;
        act = {stall_fetch, flush_id, halted, halt_pc, redirect_valid, redirect_pc};
        got = sb_q.pop_front();
        n_vec++;
        if (act !== got.exp_bits) begin
            n_miss++;
            $display("FAIL %s: got stall=%b flush=%b halted=%b hpc=%h rv=%b rpc=%h, want stall=%b flush=%b halted=%b hpc=%h rv=%b rpc=%h",
                     got.name, act[98], act[97], act[96], act[95:64], act[63], act[31:0],
                     got.exp_bits[98], got.exp_bits[97], got.exp_bits[96],
                     got.exp_bits[95:64], got.exp_bits[63], got.exp_bits[31:0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_stall = 1'b0; ex_flush = 1'b0;
        resume = 1'b0; id_instr = NOP; id_pc = '0;
`ifdef HALT_SINGLE_STEP_EN
        step = 1'b0;
`endif

        // Reset and T1: HALT at 0x40, halted 4 edges later, resume to 0x44.
        vt.push_back(mk("reset", 0, 0, 0, 0, 0, 0, NOP, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0));
        vt.push_back(mk("run_nop", 1, 1, 0, 0, 0, 0, NOP, 32'h3C, 0, 0, 0, 32'h0, 0, 32'h0));
        vt.push_back(mk("halt_invalid", 1, 0, 0, 0, 0, 0, HLT, 32'h3C, 0, 0, 0, 32'h0, 0, 32'h0));
        vt.push_back(halt_in("t1_detect", 32'h40));
        vt.push_back(drain("t1_drain1"));
        vt.push_back(drain("t1_drain2"));
        vt.push_back(drain("t1_drain3"));
        vt.push_back(hlt("t1_halted", 32'h40, 0));
        vt.push_back(hlt("t1_resume", 32'h40, 1));
        vt.push_back(rst("t1_restart", 32'h44));
        vt.push_back(mk("t1_run", 1, 1, 0, 0, 0, 0, NOP, 32'h44, 0, 0, 0, 32'h0, 0, 32'h0));
        vt.push_back(mk("resume_in_run", 1, 0, 0, 0, 1, 0, NOP, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0));
        vt.push_back(idle("resume_ignored"));
        // T2: HALT held by id_stall for two cycles.
        vt.push_back(mk("t2_stall1", 1, 1, 1, 0, 0, 0, HLT, 32'h80, 0, 0, 0, 32'h0, 0, 32'h0));
        vt.push_back(mk("t2_stall2", 1, 1, 1, 0, 0, 0, HLT, 32'h80, 0, 0, 0, 32'h0, 0, 32'h0));
        vt.push_back(halt_in("t2_detect", 32'h80));
        vt.push_back(drain("t2_drain1"));
        vt.push_back(drain("t2_drain2"));
        vt.push_back(drain("t2_drain3"));
        vt.push_back(hlt("t2_halted", 32'h80, 1));
        vt.push_back(rst("t2_restart", 32'h84));
        vt.push_back(idle("t2_run"));
        // T3: older branch resolves on the second DRAIN cycle.
        vt.push_back(halt_in("t3_detect", 32'h100));
        vt.push_back(drain("t3_drain1"));
        vt.push_back(mk("t3_exflush", 1, 0, 0, 1, 0, 0, NOP, 32'h0, 0, 1, 0, 32'h0, 0, 32'h0));
        vt.push_back(idle("t3_run1"));
        vt.push_back(idle("t3_run2"));
        vt.push_back(idle("t3_run3"));
        vt.push_back(mk("halt_with_exflush", 1, 1, 0, 1, 0, 0, HLT, 32'h104, 0, 0, 0, 32'h0, 0, 32'h0));
        // T4: restart address wraps.
        vt.push_back(halt_in("t4_detect", 32'hFFFF_FFFC));
        vt.push_back(drain("t4_drain1"));
        vt.push_back(drain("t4_drain2"));
        vt.push_back(drain("t4_drain3"));
        vt.push_back(hlt("t4_halted", 32'hFFFF_FFFC, 1));
        vt.push_back(rst("t4_restart_wrap", 32'h0));
        vt.push_back(idle("t4_run"));

        foreach (vt[i]) apply(vt[i]);

        // T5: reset asserted while HALTED, then resume after release is ignored.
        apply(halt_in("t5_detect", 32'h200));
        apply(drain("t5_drain1"));
        apply(drain("t5_drain2"));
        apply(drain("t5_drain3"));
        apply(hlt("t5_halted", 32'h200, 0));
        apply(mk("t5_async_rst", 0, 0, 0, 0, 0, 0, NOP, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0));
        apply(mk("t5_rel_resume", 1, 0, 0, 0, 1, 0, NOP, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0));
        apply(idle("t5_after1"));
        apply(idle("t5_after2"));
        apply(halt_in("t5_rehalt", 32'h300));
        apply(drain("t5_rehalt_drain"));

`ifdef HALT_SINGLE_STEP_EN
        // T6: single step from 0x40 executes the instruction at 0x44.
        apply(mk("t6_rst", 0, 0, 0, 0, 0, 0, NOP, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0));
        apply(halt_in("t6_detect", 32'h40));
        apply(drain("t6_drain1"));
        apply(drain("t6_drain2"));
        apply(drain("t6_drain3"));
        apply(mk("t6_step", 1, 0, 0, 0, 0, 1, NOP, 32'h0, 1, 1, 1, 32'h40, 0, 32'h0));
        apply(rst("t6_restart", 32'h44));
        apply(mk("t6_step_point", 1, 1, 0, 0, 0, 0, NOP, 32'h44, 1, 0, 0, 32'h0, 0, 32'h0));
        apply(drain("t6_drain1b"));
        apply(drain("t6_drain2b"));
        apply(drain("t6_drain3b"));
        apply(hlt("t6_halted_again", 32'h44, 0));
        apply(mk("t6_both", 1, 0, 0, 0, 1, 1, NOP, 32'h0, 1, 1, 1, 32'h44, 0, 32'h0));
        apply(rst("t6_restart2", 32'h48));
        apply(mk("t6_no_step", 1, 1, 0, 0, 0, 0, NOP, 32'h48, 0, 0, 0, 32'h0, 0, 32'h0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog: the run is a fixed number of cycles, so this only fires on a
    // stuck simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1);
    end

endmodule : tb_halt_controller
